// File: rtl/shift_req_sched.sv
// ---------------------------------------------------------------------------
// shift_req_sched
//
// Two requesters, A and B, share one combinational 64-bit ones-fill right
// shifter. The shifter handles 0-31 bits per use. Requesters are arbitrated
// round-robin and may ask for shift amounts of 0-127. Each accepted operation
// is split into passes of at most 31 bits, one pass per clock. The result and
// the requester ID are returned on a valid/ready response port.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   req_valid_a/b            requester has an operation pending
//   req_ready_a/b            operation accepted this cycle (combinational)
//   D_in_a/b [63:0]          operand
//   samt_a/b [6:0]           shift amount, 0-127 (64 and above give all ones)
//   resp_valid, resp_ready   response handshake
//   D_out [63:0]             shifted result, mirrors the working data register
//   resp_id                  0 = A, 1 = B
//   busy                     scheduler is not idle
//   op_count [CNTW-1:0]      completed responses, wraps
// ---------------------------------------------------------------------------
module shift_req_sched #(
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid_a,
   output logic            req_ready_a,
   input  logic [63:0]     D_in_a,
   input  logic [6:0]      samt_a,
   input  logic            req_valid_b,
   output logic            req_ready_b,
   input  logic [63:0]     D_in_b,
   input  logic [6:0]      samt_b,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [63:0]     D_out,
   output logic            resp_id,
   output logic            busy,
   output logic [CNTW-1:0] op_count
);

   // Largest shift the shared shifter applies in one pass. It is tied to the
   // 5-bit shifter amount and is not meant to be overridden.
   localparam int MAXP = 31;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [63:0]     data_q, data_d;
   logic [6:0]      rem_q, rem_d;
   logic            resp_id_q, resp_id_d;
   logic            last_grant_q, last_grant_d;
   logic            resp_valid_q, resp_valid_d;
   logic            busy_q, busy_d;
   logic [CNTW-1:0] op_count_q, op_count_d;

   logic            grant_a;
   logic            grant_b;
   logic [6:0]      sel_samt;
   logic [6:0]      eff_samt;
   logic [63:0]     sel_data;
   logic [4:0]      pass_amt;
   logic [63:0]     shift_out;

   // Round-robin grant. last_grant_q = 1 means B won last time, so A has
   // priority when both requesters are asking. Exactly one grant is high
   // whenever any valid is high.
   always_comb begin
      grant_a = req_valid_a & (~req_valid_b | last_grant_q);
      grant_b = req_valid_b & ~grant_a;
   end

   // Readies depend on the grant and the current state. No accept is
   // possible outside IDLE, which keeps the requesters stalled while an
   // operation is in flight.
   always_comb begin
      req_ready_a = (state_q == IDLE) & grant_a;
      req_ready_b = (state_q == IDLE) & grant_b;
   end

   // Operand selection for the winning requester. Shifts of 64 or more all
   // produce a word of ones, so the amount is clamped to 64. This keeps the
   // worst case at three passes (31, 31, 2).
   always_comb begin
      sel_samt = grant_b ? samt_b : samt_a;
      sel_data = grant_b ? D_in_b : D_in_a;
      eff_samt = (sel_samt > 7'd64) ? 7'd64 : sel_samt;
   end

   // Each pass takes as much of the remaining shift as the shifter can
   // apply, up to 31 bits.
   always_comb begin
      pass_amt = (rem_q > 7'(MAXP)) ? 5'(MAXP) : rem_q[4:0];
   end

   barrel_shift_right_1 u_shifter (
      .D_in  (data_q),
      .samt  (pass_amt),
      .D_out (shift_out)
   );

   // Next-state logic for the scheduler. resp_valid and busy are computed
   // together with the state, so the outputs come straight from flops. A
   // response handshake sends the FSM back to IDLE without accepting a new
   // request in the same cycle. This leaves a one-cycle bubble between
   // operations.
   always_comb begin
      state_d      = state_q;
      data_d       = data_q;
      rem_d        = rem_q;
      resp_id_d    = resp_id_q;
      last_grant_d = last_grant_q;
      resp_valid_d = resp_valid_q;
      busy_d       = busy_q;
      op_count_d   = op_count_q;

      case (state_q)
         IDLE: begin
            if (grant_a | grant_b) begin
               data_d       = sel_data;
               rem_d        = eff_samt;
               resp_id_d    = grant_b;
               last_grant_d = grant_b;
               busy_d       = 1'b1;
               if (eff_samt == 7'd0) begin
                  state_d      = DONE;
                  resp_valid_d = 1'b1;
               end else begin
                  state_d = SHIFT;
               end
            end
         end

         SHIFT: begin
            data_d = shift_out;
            rem_d  = rem_q - {2'b00, pass_amt};
            if (rem_d == 7'd0) begin
               state_d      = DONE;
               resp_valid_d = 1'b1;
            end
         end

         DONE: begin
            if (resp_ready) begin
               state_d      = IDLE;
               resp_valid_d = 1'b0;
               busy_d       = 1'b0;
               op_count_d   = op_count_q + CNTW'(1);
            end
         end

         default: begin
            state_d      = IDLE;
            resp_valid_d = 1'b0;
            busy_d       = 1'b0;
         end
      endcase
   end

   // State register. Reset abandons any operation in flight. It sets
   // last_grant to B so that A wins the first contention.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         data_q       <= '0;
         rem_q        <= '0;
         resp_id_q    <= 1'b0;
         last_grant_q <= 1'b1;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         op_count_q   <= '0;
      end else begin
         state_q      <= state_d;
         data_q       <= data_d;
         rem_q        <= rem_d;
         resp_id_q    <= resp_id_d;
         last_grant_q <= last_grant_d;
         resp_valid_q <= resp_valid_d;
         busy_q       <= busy_d;
         op_count_q   <= op_count_d;
      end
   end

   // D_out always mirrors the data register. Its value only matters while
   // resp_valid is high.
   always_comb begin
      resp_valid = resp_valid_q;
      D_out      = data_q;
      resp_id    = resp_id_q;
      busy       = busy_q;
      op_count   = op_count_q;
   end

endmodule

// ---------------------------------------------------------------------------
// barrel_shift_right_1
//
// Combinational 64-bit logical right shifter that fills vacated bits with
// ones. It has five binary-weighted stages.
//
// Ports:
//   D_in [63:0]   operand
//   samt [4:0]    shift amount, 0-31
//   D_out [63:0]  D_in shifted right by samt, ones shifted in at the top
// ---------------------------------------------------------------------------
module barrel_shift_right_1 (
   input  logic [63:0] D_in,
   input  logic [4:0]  samt,
   output logic [63:0] D_out
);

   logic [63:0] st1, st2, st4, st8;

   // Each stage applies one bit of the shift amount. Stages cascade from
   // the least significant bit.
   always_comb begin
      st1   = samt[0] ? {1'b1,          D_in[63:1]} : D_in;
      st2   = samt[1] ? {2'b11,         st1[63:2]}  : st1;
      st4   = samt[2] ? {4'hF,          st2[63:4]}  : st2;
      st8   = samt[3] ? {8'hFF,         st4[63:8]}  : st4;
      D_out = samt[4] ? {16'hFFFF,      st8[63:16]} : st8;
   end

endmodule

// File: tb/tb_shift_req_sched.sv
// ---------------------------------------------------------------------------
// tb_shift_req_sched
//
// Drives directed and randomized operations into shift_req_sched. Each
// result is compared against a behavioural model. The model computes the
// result as one whole-word ones-fill shift. It computes the expected latency
// from the pass-count formula and tracks round-robin fairness with a single
// "B won last" flag.
// ---------------------------------------------------------------------------
module tb_shift_req_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_a;
   logic        req_ready_a;
   logic [63:0] D_in_a;
   logic [6:0]  samt_a;
   logic        req_valid_b;
   logic        req_ready_b;
   logic [63:0] D_in_b;
   logic [6:0]  samt_b;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] D_out;
   logic        resp_id;
   logic        busy;
   logic [15:0] op_count;

   int errors = 0;
   int checks = 0;

   // Reference model state.
   bit lastB   = 1'b1;
   int opModel = 0;

   localparam logic [63:0] OPND = 64'h0123_4567_89AB_CDEF;

   shift_req_sched #(.CNTW(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_a (req_valid_a),
      .req_ready_a (req_ready_a),
      .D_in_a      (D_in_a),
      .samt_a      (samt_a),
      .req_valid_b (req_valid_b),
      .req_ready_b (req_ready_b),
      .D_in_b      (D_in_b),
      .samt_b      (samt_b),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .D_out       (D_out),
      .resp_id     (resp_id),
      .busy        (busy),
      .op_count    (op_count)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Backstop so the run always ends, even if the flow below misbehaves.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Whole-word ones-fill right shift. Any amount of 64 or more yields all
   // ones.
   function automatic logic [63:0] refShift(input logic [63:0] d, input int s);
      logic [63:0] inv;
      if (s >= 64) return '1;
      inv = ~d;
      return ~(inv >> s);
   endfunction

   // Number of passes: ceil(min(S,64)/31).
   function automatic int refPasses(input int s);
      int e;
      e = (s > 64) ? 64 : s;
      return (e + 30) / 31;
   endfunction

   // Single comparison point. Counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drives both request ports with blocking assignments.
   task automatic applyStimulus(input logic va, input logic [63:0] da, input logic [6:0] sa,
                                input logic vb, input logic [63:0] db, input logic [6:0] sb);
      req_valid_a = va;
      D_in_a      = da;
      samt_a      = sa;
      req_valid_b = vb;
      D_in_b      = db;
      samt_b      = sb;
   endtask

   // Holds reset across two clock edges, then clears the model.
   task automatic pulseReset();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst     = 1'b0;
      lastB   = 1'b1;
      opModel = 0;
   endtask

   // Runs one full operation: accept, wait for the response, optionally
   // stall the consumer, then complete the handshake. The task is entered
   // and left 1 time unit after a rising edge, with the DUT in IDLE.
   task automatic doOp(input logic va, input logic [63:0] da, input logic [6:0] sa,
                       input logic vb, input logic [63:0] db, input logic [6:0] sb,
                       input int holdCycles, input bit keepValid);
      bit          gB;
      logic [63:0] expData;
      int          expP;
      int          k;

      applyStimulus(va, da, sa, vb, db, sb);
      #1;
      gB      = (va && vb) ? !lastB : vb;
      expData = refShift(gB ? db : da, gB ? int'(sb) : int'(sa));
      expP    = refPasses(gB ? int'(sb) : int'(sa));
      checkOutput("ready_a", 64'(req_ready_a), 64'(!gB));
      checkOutput("ready_b", 64'(req_ready_b), 64'(gB));
      lastB = gB;

      @(posedge clk);
      #1;
      if (!keepValid) applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);

      k = 0;
      while (!resp_valid && k < 10) begin
         checkOutput("ready_while_busy", 64'({req_ready_a, req_ready_b}), 64'd0);
         checkOutput("busy", 64'(busy), 64'd1);
         @(posedge clk);
         #1;
         k++;
      end
      checkOutput("latency", 64'(k), 64'(expP));

      for (int h = 0; h < holdCycles; h++) begin
         checkOutput("hold_d_out", D_out, expData);
         checkOutput("hold_resp_id", 64'(resp_id), 64'(gB));
         checkOutput("hold_valid", 64'(resp_valid), 64'd1);
         @(posedge clk);
         #1;
      end

      checkOutput("d_out", D_out, expData);
      checkOutput("resp_id", 64'(resp_id), 64'(gB));
      checkOutput("ready_in_done", 64'({req_ready_a, req_ready_b}), 64'd0);

      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      opModel++;
      checkOutput("valid_after_hs", 64'(resp_valid), 64'd0);
      checkOutput("op_count", 64'(op_count), 64'(opModel & 16'hFFFF));
   endtask

   initial begin
      logic [6:0] boundaries [12];
      logic       va, vb;
      logic [6:0] sa, sb;

      boundaries = '{7'd0, 7'd1, 7'd30, 7'd31, 7'd32, 7'd33,
                     7'd62, 7'd63, 7'd64, 7'd65, 7'd93, 7'd127};

      rst        = 1'b1;
      resp_ready = 1'b0;
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("reset_valid", 64'(resp_valid), 64'd0);
      checkOutput("reset_d_out", D_out, 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_count", 64'(op_count), 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Directed single-requester cases covering the pass boundaries.
      doOp(1'b1, OPND, 7'd0,   1'b0, '0, '0,     0, 1'b0);
      checkOutput("dir_s0_count", 64'(op_count), 64'd1);
      doOp(1'b1, OPND, 7'd4,   1'b0, '0, '0,     0, 1'b0);
      doOp(1'b0, '0, '0,       1'b1, OPND, 7'd40, 0, 1'b0);
      doOp(1'b1, OPND, 7'd100, 1'b0, '0, '0,     1, 1'b0);
      doOp(1'b1, OPND, 7'd32,  1'b0, '0, '0,     0, 1'b0);
      doOp(1'b0, '0, '0,       1'b1, OPND, 7'd31, 0, 1'b0);

      // Contention after reset: A, B, A, B, with one long consumer stall.
      pulseReset();
      for (int i = 0; i < 4; i++)
         doOp(1'b1, OPND, 7'd4, 1'b1, ~OPND, 7'd4, (i == 1) ? 5 : 0, 1'b1);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);

      // Randomized mix of requesters, operands, amounts and stalls.
      for (int i = 0; i < 40; i++) begin
         va = 1'($urandom % 2);
         vb = 1'($urandom % 2);
         if (!va && !vb) va = 1'b1;
         sa = ($urandom % 2 == 0) ? boundaries[$urandom % 12] : 7'($urandom_range(0, 127));
         sb = ($urandom % 2 == 0) ? boundaries[$urandom % 12] : 7'($urandom_range(0, 127));
         doOp(va, {$urandom, $urandom}, sa, vb, {$urandom, $urandom}, sb,
              $urandom_range(0, 3), 1'($urandom % 2));
         applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      end

      // Reset during the second shift pass of a 64-bit shift.
      applyStimulus(1'b1, OPND, 7'd64, 1'b0, '0, '0);
      #1;
      checkOutput("mid_ready_a", 64'(req_ready_a), 64'd1);
      @(posedge clk);
      #1;
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      @(posedge clk);
      #1;
      checkOutput("mid_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      checkOutput("async_valid", 64'(resp_valid), 64'd0);
      checkOutput("async_busy", 64'(busy), 64'd0);
      checkOutput("async_d_out", D_out, 64'd0);
      checkOutput("async_resp_id", 64'(resp_id), 64'd0);
      checkOutput("async_count", 64'(op_count), 64'd0);
      @(posedge clk);
      #1;
      rst     = 1'b0;
      lastB   = 1'b1;
      opModel = 0;
      for (int i = 0; i < 4; i++) begin
         checkOutput("no_stale_valid", 64'(resp_valid), 64'd0);
         @(posedge clk);
         #1;
      end
      checkOutput("post_reset_count", 64'(op_count), 64'd0);
      doOp(1'b1, OPND, 7'd4, 1'b1, ~OPND, 7'd4, 0, 1'b1);
      doOp(1'b1, OPND, 7'd4, 1'b1, ~OPND, 7'd4, 0, 1'b1);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
